// File: rtl/inference_sequencer.sv
// Inference sequencer: streams one image from memory into the dnn, then waits for its class.
// Ports: req_* request handshake, mem_* image reads, x_* pixel stream, class_* dnn result, rsp_* response.
module inference_sequencer #(
  parameter int data_width     = 16,
  parameter int num_pixels     = 784,
  parameter int addr_width     = 16,
  parameter int timeout_cycles = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [addr_width-1:0] req_base,
  output logic                  mem_rd_en,
  output logic [addr_width-1:0] mem_addr,
  input  logic [data_width-1:0] mem_rd_data,
  output logic [data_width-1:0] x_data,
  output logic                  x_valid,
  input  logic [3:0]            class_id_in,
  input  logic                  class_valid_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [3:0]            rsp_class,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [15:0]           infer_count
);

  localparam int PW = (num_pixels > 1) ? $clog2(num_pixels) : 1;
  localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [addr_width-1:0] mem_addr_q, mem_addr_d;
  logic [data_width-1:0] x_data_q, x_data_d;
  logic                  x_valid_q, x_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [3:0]            rsp_class_q, rsp_class_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  busy_q, busy_d;
  logic [15:0]           infer_count_q, infer_count_d;

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    mem_addr_d    = mem_addr_q;
    rsp_class_d   = rsp_class_q;
    rsp_error_d   = rsp_error_q;
    infer_count_d = infer_count_q;
    // Read data returns on the edge closing the read cycle, so the
    // pixel beat trails its read strobe by exactly one cycle.
    x_valid_d     = mem_rd_en_q;
    x_data_d      = mem_rd_en_q ? mem_rd_data : x_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d    = S_STREAM;
          mem_addr_d = req_base;
          pix_cnt_d  = '0;
        end
      end
      S_STREAM: begin
        if (pix_cnt_q == PW'(num_pixels - 1)) begin
          state_d   = S_WAIT;
          tmo_cnt_d = '0;
        end else begin
          pix_cnt_d  = pix_cnt_q + PW'(1);
          mem_addr_d = mem_addr_q + addr_width'(1);
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still wins.
        if (class_valid_in) begin
          state_d     = S_DONE;
          rsp_class_d = class_id_in;
          rsp_error_d = 1'b0;
        end else if (tmo_cnt_q == TW'(timeout_cycles - 1)) begin
          state_d     = S_DONE;
          rsp_class_d = 4'hF;
          rsp_error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d       = S_IDLE;
          infer_count_d = infer_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs follow the next state so they stay registered.
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    mem_rd_en_d = (state_d == S_STREAM);
    rsp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pix_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      req_ready_q   <= 1'b1;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      x_data_q      <= '0;
      x_valid_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_class_q   <= 4'h0;
      rsp_error_q   <= 1'b0;
      busy_q        <= 1'b0;
      infer_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      req_ready_q   <= req_ready_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      x_data_q      <= x_data_d;
      x_valid_q     <= x_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_class_q   <= rsp_class_d;
      rsp_error_q   <= rsp_error_d;
      busy_q        <= busy_d;
      infer_count_q <= infer_count_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign x_data      = x_data_q;
  assign x_valid     = x_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_class   = rsp_class_q;
  assign rsp_error   = rsp_error_q;
  assign busy        = busy_q;
  assign infer_count = infer_count_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed self-checking bench for inference_sequencer (4 pixels, timeout of 8 cycles).
// Memory model returns (addr[1:0] + 1) combinationally while mem_rd_en is high.
module tb_inference_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_base = 16'h0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] x_data;
  logic        x_valid;
  logic [3:0]  class_id_in = 4'h0;
  logic        class_valid_in = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_class;
  logic        rsp_error;
  logic        busy;
  logic [15:0] infer_count;

  int n_chk = 0;
  int n_fail = 0;

  inference_sequencer #(
    .data_width(16), .num_pixels(4), .addr_width(16), .timeout_cycles(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .x_data(x_data), .x_valid(x_valid),
    .class_id_in(class_id_in), .class_valid_in(class_valid_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_class(rsp_class), .rsp_error(rsp_error),
    .busy(busy), .infer_count(infer_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rd_data = 16'hDEAD;
    if (mem_rd_en) mem_rd_data = {14'd0, mem_addr[1:0]} + 16'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout required finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Handshake in the current cycle, then check the four reads and beats.
  // Returns in the first WAIT cycle.
  task automatic do_stream(input logic [15:0] base,
                           input logic [15:0] e0, e1, e2, e3);
    logic [15:0] ev [4];
    ev = '{e0, e1, e2, e3};
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_ready got %b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_base  = base;
    for (int k = 0; k < 4; k++) begin
      step;
      req_valid = 1'b0;
      n_chk++;
      if (mem_rd_en !== 1'b1 || mem_addr !== base + 16'(k)) begin
        n_fail++;
        $display("FAIL rd_%0d got en=%b addr=%h required en=1 addr=%h",
                 k, mem_rd_en, mem_addr, base + 16'(k));
      end
      n_chk++;
      if (k == 0) begin
        if (x_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL first_stream got xv=%b busy=%b rdy=%b required 0 1 0",
                   x_valid, busy, req_ready);
        end
      end else if (x_valid !== 1'b1 || x_data !== ev[k-1]) begin
        n_fail++;
        $display("FAIL beat_%0d got xv=%b x=%h required xv=1 x=%h",
                 k - 1, x_valid, x_data, ev[k-1]);
      end
    end
    step;
    n_chk++;
    if (mem_rd_en !== 1'b0 || x_valid !== 1'b1 || x_data !== ev[3]) begin
      n_fail++;
      $display("FAIL last_beat got en=%b xv=%b x=%h required en=0 xv=1 x=%h",
               mem_rd_en, x_valid, x_data, ev[3]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step;
    step;
    rst = 1'b1;
    n_chk++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mem_rd_en !== 1'b0 ||
        x_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got rdy=%b busy=%b en=%b xv=%b rv=%b err=%b required 1 0 0 0 0 0",
               req_ready, busy, mem_rd_en, x_valid, rsp_valid, rsp_error);
    end
    n_chk++;
    if (mem_addr !== 16'h0 || x_data !== 16'h0 || rsp_class !== 4'h0 ||
        infer_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%h x=%h cls=%h cnt=%h required all 0",
               mem_addr, x_data, rsp_class, infer_count);
    end
  endtask

  task automatic test_basic;
    do_stream(16'h0010, 16'd1, 16'd2, 16'd3, 16'd4);
    for (int i = 0; i < 5; i++) begin
      step;
      n_chk++;
      if (rsp_valid !== 1'b0 || x_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_wait_%0d got rv=%b xv=%b required 0 0", i, rsp_valid, x_valid);
      end
    end
    class_valid_in = 1'b1;
    class_id_in    = 4'd7;
    step;
    class_valid_in = 1'b0;
    class_id_in    = 4'd0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_class !== 4'd7 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rsp got rv=%b cls=%h err=%b required 1 7 0",
               rsp_valid, rsp_class, rsp_error);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 ||
        infer_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_done got rv=%b rdy=%b busy=%b cnt=%0d required 0 1 0 1",
               rsp_valid, req_ready, busy, infer_count);
    end
  endtask

  task automatic test_timeout_wrap;
    do_stream(16'hFFFE, 16'd3, 16'd4, 16'd1, 16'd2);
    for (int i = 0; i < 7; i++) begin
      step;
      n_chk++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_early_%0d got rv=%b required 0", i, rsp_valid);
      end
    end
    step;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_class !== 4'hF || rsp_error !== 1'b1 ||
        infer_count !== 16'd1) begin
      n_fail++;
      $display("FAIL tmo_rsp got rv=%b cls=%h err=%b cnt=%0d required 1 f 1 1",
               rsp_valid, rsp_class, rsp_error, infer_count);
    end
  endtask

  task automatic test_hold_back_to_back;
    req_valid = 1'b1;
    req_base  = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      step;
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_class !== 4'hF || rsp_error !== 1'b1 ||
          req_ready !== 1'b0 || mem_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d got rv=%b cls=%h err=%b rdy=%b en=%b required 1 f 1 0 0",
                 i, rsp_valid, rsp_class, rsp_error, req_ready, mem_rd_en);
      end
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || infer_count !== 16'd2) begin
      n_fail++;
      $display("FAIL hold_release got rv=%b rdy=%b cnt=%0d required 0 1 2",
               rsp_valid, req_ready, infer_count);
    end
  endtask

  task automatic test_tie;
    do_stream(16'h0010, 16'd1, 16'd2, 16'd3, 16'd4);
    for (int i = 0; i < 7; i++) step;
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_pre got rv=%b required 0", rsp_valid);
    end
    class_valid_in = 1'b1;
    class_id_in    = 4'd3;
    step;
    class_valid_in = 1'b0;
    class_id_in    = 4'd0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_class !== 4'd3 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_rsp got rv=%b cls=%h err=%b required 1 3 0",
               rsp_valid, rsp_class, rsp_error);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    n_chk++;
    if (infer_count !== 16'd3 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_done got cnt=%0d rdy=%b required 3 1", infer_count, req_ready);
    end
  endtask

  task automatic test_spurious;
    class_valid_in = 1'b1;
    class_id_in    = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step;
      n_chk++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
          rsp_class !== 4'd3) begin
        n_fail++;
        $display("FAIL spurious_%0d got rv=%b busy=%b rdy=%b cls=%h required 0 0 1 3",
                 i, rsp_valid, busy, req_ready, rsp_class);
      end
    end
    class_valid_in = 1'b0;
    class_id_in    = 4'd0;
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1;
    req_base  = 16'h0020;
    step;
    req_valid = 1'b0;
    step;
    step;
    n_chk++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0022 || x_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre got en=%b addr=%h xv=%b required 1 0022 1",
               mem_rd_en, mem_addr, x_valid);
    end
    rst = 1'b0;
    step;
    rst = 1'b1;
    n_chk++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mem_rd_en !== 1'b0 ||
        x_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ctl got rdy=%b busy=%b en=%b xv=%b rv=%b err=%b required 1 0 0 0 0 0",
               req_ready, busy, mem_rd_en, x_valid, rsp_valid, rsp_error);
    end
    n_chk++;
    if (mem_addr !== 16'h0 || x_data !== 16'h0 || rsp_class !== 4'h0 ||
        infer_count !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_rst_data got addr=%h x=%h cls=%h cnt=%h required all 0",
               mem_addr, x_data, rsp_class, infer_count);
    end
    for (int i = 0; i < 12; i++) begin
      step;
      n_chk++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || x_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_after_%0d got rv=%b busy=%b xv=%b required 0 0 0",
                 i, rsp_valid, busy, x_valid);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_timeout_wrap;
    test_hold_back_to_back;
    test_tie;
    test_spurious;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 Parameter data_width, default 16, pixel width, equal to the dnn input width.
REQ-002 Parameter num_pixels, default 784, pixels streamed per inference.
REQ-003 Parameter addr_width, default 16, image memory address width.
REQ-004 Parameter timeout_cycles, default 65535, maximum WAIT duration before an error response.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  1  inference request.
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_base  input  addr_width  image base address.
REQ-010 mem_rd_en  output  1  image memory read strobe.
REQ-011 mem_addr  output  addr_width  image memory read address.
REQ-012 mem_rd_data  input  data_width  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 x_data  output  data_width  pixel to dnn.
REQ-014 x_valid  output  1  pixel strobe to dnn.
REQ-015 class_id_in  input  4  dnn class result.
REQ-016 class_valid_in  input  1  dnn result strobe (single cycle).
REQ-017 rsp_valid  output  1  result available.
REQ-018 rsp_ready  input  1  consumer accepts result.
REQ-019 rsp_class  output  4  captured class id.
REQ-020 rsp_error  output  1  1 = timeout, no result from dnn.
REQ-021 busy  output  1  state is not IDLE.
REQ-022 infer_count  output  16  completed response handshakes.

Function
REQ-023 FSM states: IDLE, STREAM, WAIT, DONE; all outputs registered.
REQ-024 IDLE: req_ready=1; on req_valid&&req_ready latch req_base and go STREAM next cycle; req_ready=0 in every other state.
REQ-025 STREAM: mem_rd_en=1 for exactly num_pixels consecutive cycles, mem_addr=base+k for k=0..num_pixels-1, sum truncated mod 2^addr_width (wrap-around allowed).
REQ-026 x_valid asserts the cycle after each mem_rd_en with x_data=mem_rd_data, giving num_pixels contiguous beats with no gaps; the last beat lands in the first WAIT cycle.
REQ-027 After the last read, go WAIT; timeout counter clears to 0 on WAIT entry and increments each WAIT cycle.
REQ-028 WAIT: class_valid_in=1 captures class_id_in into rsp_class, sets rsp_error=0, goes DONE.
REQ-029 WAIT: counter at timeout_cycles-1 without class_valid_in sets rsp_class=4'hF, rsp_error=1, goes DONE.
REQ-030 Simultaneous class_valid_in and timeout: class_valid_in wins, rsp_error=0.
REQ-031 class_valid_in outside WAIT is ignored; no state or output change.
REQ-032 DONE: rsp_valid=1; rsp_class and rsp_error held stable until rsp_ready=1; handshake returns to IDLE next cycle and increments infer_count (wraps 16'hFFFF->0).
REQ-033 req_valid during a busy state is not accepted; the requester holds it until req_ready.
REQ-034 Minimum request-to-first-x_valid latency: 2 cycles after the handshake cycle.

Reset
REQ-035 rst=0 at a clock edge forces IDLE; req_ready=1; mem_rd_en, x_valid, rsp_valid, rsp_error, busy=0; mem_addr, x_data, rsp_class, infer_count, timeout counter=0.
REQ-036 Reset mid-STREAM or mid-WAIT aborts the inference with no response; x_valid drops the following edge; dnn is reset by the system in the same cycle.

Verification
REQ-037 num_pixels=4, base=16'h0010, memory holds 1,2,3,4; dnn result class 7 after 10 cycles -> mem_addr 10..13, x_data 1,2,3,4 on consecutive cycles, rsp_class=7, rsp_error=0, infer_count=1.
REQ-038 base=16'hFFFE, num_pixels=4 -> mem_addr FFFE,FFFF,0000,0001.
REQ-039 timeout_cycles=8, no class_valid_in -> rsp_valid after 8 WAIT cycles, rsp_class=F, rsp_error=1.
REQ-040 class_valid_in in the same cycle as the timeout -> rsp_error=0 with the captured class; spurious class_valid_in in IDLE -> no rsp_valid.
REQ-041 rsp_ready held low 5 cycles -> rsp_valid and rsp_class stable for 5 cycles; second req_valid held throughout is accepted only after return to IDLE.
REQ-042 rst=0 in the third STREAM cycle -> next edge all outputs at reset values, busy=0, no response emitted.
